// File: rtl/kruskal_mst_core.sv
// rtl/kruskal_mst_core.sv - Kruskal MST engine over byte-addressed memories with a two-channel slave RAM port
// Optional macro PATH_HALVING_EN: the find walk also rewrites parent[x] = parent[parent[x]].
module kruskal_mst_core (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_port,
    output logic        done_port,
    input  logic [1:0]  S_oe_ram,
    input  logic [1:0]  S_we_ram,
    input  logic [21:0] S_addr_ram,
    input  logic [15:0] S_Wdata_ram,
    input  logic [7:0]  S_data_ram_size,
    input  logic [15:0] M_Rdata_ram,
    input  logic [1:0]  M_DataRdy,
    output logic [15:0] Sout_Rdata_ram,
    output logic [1:0]  Sout_DataRdy,
    output logic [1:0]  Mout_oe_ram,
    output logic [1:0]  Mout_we_ram,
    output logic [21:0] Mout_addr_ram,
    output logic [15:0] Mout_Wdata_ram,
    output logic [7:0]  Mout_data_ram_size
);
    localparam logic [10:0] MEM_var_28867_28882 = 11'd128;
    localparam logic [10:0] MEM_var_28868_28882 = 11'd256;
    localparam logic [10:0] MEM_var_28869_28882 = 11'd384;
    localparam logic [10:0] MEM_var_28870_28882 = 11'd512;
    localparam logic [10:0] MEM_var_28859_28880 = 11'd640;
    localparam logic [10:0] MEM_var_28861_28880 = 11'd768;
    localparam logic [10:0] MEM_var_28862_28880 = 11'd896;
    localparam logic [10:0] MEM_var_28864_28880 = 11'd1024;
    localparam logic [10:0] MEM_var_28865_28880 = 11'd1152;
    localparam logic [10:0] MEM_var_28866_28880 = 11'd1280;
    localparam int          MEM_BYTES = 1280;
    localparam int          NWP       = 5;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_FETCH, S_FIND_U, S_FIND_V, S_UNION, S_FINISH
    } state_t;

    // All ten regions live in one flat array starting at the first base address.
    function automatic logic [10:0] off(input logic [10:0] a);
        return a - MEM_var_28867_28882;
    endfunction

    function automatic logic in_mem(input logic [10:0] a);
        return (a >= MEM_var_28867_28882) && (a < MEM_var_28866_28880 + 11'd128);
    endfunction

    logic [7:0]     mem_q [0:MEM_BYTES-1];
    logic [NWP-1:0] wr_en;
    logic [10:0]    wr_addr [NWP];
    logic [7:0]     wr_data [NWP];

    state_t      state_q, state_d;
    logic [7:0]  n_q, n_d, e_q, e_d, k_q, k_d, i_q, i_d, x_q, x_d, steps_q, steps_d;
    logic [7:0]  u_q, u_d, v_q, v_d, w_q, w_d, ru_q, ru_d, rv_q, rv_d, count_q, count_d;
    logic [15:0] total_q, total_d;
    logic [1:0]  rdy_q, rdy_d;
    logic [15:0] rdata_q, rdata_d;

    logic [10:0] s_addr [2];
    logic [1:0]  s_rd, s_wr;
    logic [7:0]  cfg_n, cfg_e, eu, ev, ew, par_x, par_p, step_x, init_lim;
    logic        term, skip, at_root, init_last;
    logic        unused_inputs;

    assign unused_inputs = ^{S_data_ram_size, M_Rdata_ram, M_DataRdy};

    assign s_addr[0] = S_addr_ram[10:0];
    assign s_addr[1] = S_addr_ram[21:11];

    assign cfg_n = mem_q[off(MEM_var_28859_28880)];
    assign cfg_e = mem_q[off(MEM_var_28859_28880 + 11'd1)];
    assign eu    = mem_q[off(MEM_var_28867_28882 + {3'b000, k_q})];
    assign ev    = mem_q[off(MEM_var_28868_28882 + {3'b000, k_q})];
    assign ew    = mem_q[off(MEM_var_28869_28882 + {3'b000, k_q})];
    assign par_x = mem_q[off(MEM_var_28870_28882 + {3'b000, x_q})];
    assign par_p = mem_q[off(MEM_var_28870_28882 + {3'b000, par_x})];

    assign term      = (k_q >= e_q) || (n_q <= 8'd1) || (count_q == n_q - 8'd1);
    assign skip      = (eu >= n_q) || (ev >= n_q) || (eu == ev);
    assign at_root   = (par_x == x_q) || (steps_q >= n_q);
    assign init_lim  = (n_q > e_q) ? n_q : e_q;
    assign init_last = ({1'b0, i_q} + 9'd1) >= {1'b0, init_lim};
`ifdef PATH_HALVING_EN
    assign step_x = par_p;
`else
    assign step_x = par_x;
`endif

    always_comb begin
        s_rd    = '0;
        s_wr    = '0;
        rdy_d   = '0;
        rdata_d = '0;
        for (int c = 0; c < 2; c++) begin
            s_rd[c]  = (state_q == S_IDLE) && S_oe_ram[c] && !S_we_ram[c] && in_mem(s_addr[c]);
            s_wr[c]  = (state_q == S_IDLE) && S_we_ram[c] && !S_oe_ram[c] && in_mem(s_addr[c]);
            rdy_d[c] = s_rd[c] || s_wr[c];
            rdata_d[c*8 +: 8] = s_rd[c] ? mem_q[off(s_addr[c])] : 8'h00;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_port) state_d = S_INIT;
            S_INIT:   if (init_last) state_d = S_FETCH;
            S_FETCH:  if (term) state_d = S_FINISH;
                      else if (!skip) state_d = S_FIND_U;
            S_FIND_U: if (at_root) state_d = S_FIND_V;
            S_FIND_V: if (at_root) state_d = S_UNION;
            S_UNION:  state_d = S_FETCH;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Port order matters: a later port overrides an earlier one, so ch1 beats ch0.
    always_comb begin
        done_port = 1'b0;
        wr_en     = '0;
        for (int p = 0; p < NWP; p++) begin
            wr_addr[p] = '0;
            wr_data[p] = '0;
        end
        case (state_q)
            S_IDLE: begin
                wr_en[0] = s_wr[0]; wr_addr[0] = s_addr[0]; wr_data[0] = S_Wdata_ram[7:0];
                wr_en[1] = s_wr[1]; wr_addr[1] = s_addr[1]; wr_data[1] = S_Wdata_ram[15:8];
            end
            S_INIT: begin
                wr_en[0] = i_q < n_q; wr_addr[0] = MEM_var_28870_28882 + {3'b000, i_q}; wr_data[0] = i_q;
                wr_en[1] = i_q < e_q; wr_addr[1] = MEM_var_28866_28880 + {3'b000, i_q}; wr_data[1] = 8'h00;
            end
`ifdef PATH_HALVING_EN
            S_FIND_U, S_FIND_V: begin
                wr_en[0] = !at_root; wr_addr[0] = MEM_var_28870_28882 + {3'b000, x_q}; wr_data[0] = par_p;
            end
`endif
            S_UNION: if (ru_q != rv_q) begin
                wr_en      = '1;
                wr_addr[0] = MEM_var_28870_28882 + {3'b000, ru_q};    wr_data[0] = rv_q;
                wr_addr[1] = MEM_var_28861_28880 + {3'b000, count_q}; wr_data[1] = u_q;
                wr_addr[2] = MEM_var_28862_28880 + {3'b000, count_q}; wr_data[2] = v_q;
                wr_addr[3] = MEM_var_28864_28880 + {3'b000, count_q}; wr_data[3] = w_q;
                wr_addr[4] = MEM_var_28866_28880 + {3'b000, k_q};     wr_data[4] = 8'h01;
            end
            S_FINISH: begin
                done_port  = 1'b1;
                wr_en[2:0] = 3'b111;
                wr_addr[0] = MEM_var_28865_28880;         wr_data[0] = count_q;
                wr_addr[1] = MEM_var_28865_28880 + 11'd1; wr_data[1] = total_q[7:0];
                wr_addr[2] = MEM_var_28865_28880 + 11'd2; wr_data[2] = total_q[15:8];
            end
            default: ;
        endcase
    end

    always_comb begin
        n_d = n_q; e_d = e_q; k_d = k_q; i_d = i_q; x_d = x_q; steps_d = steps_q;
        u_d = u_q; v_d = v_q; w_d = w_q; ru_d = ru_q; rv_d = rv_q;
        count_d = count_q; total_d = total_q;
        case (state_q)
            S_IDLE: if (start_port) begin
                n_d = (cfg_n > 8'd28) ? 8'd28 : cfg_n;
                e_d = (cfg_e > 8'd128) ? 8'd128 : cfg_e;
                i_d = 8'd0;
            end
            S_INIT: begin
                i_d = i_q + 8'd1; k_d = 8'd0; count_d = 8'd0; total_d = 16'd0;
            end
            S_FETCH: if (!term) begin
                if (skip) k_d = k_q + 8'd1;
                else begin
                    u_d = eu; v_d = ev; w_d = ew; x_d = eu; steps_d = 8'd0;
                end
            end
            S_FIND_U: if (at_root) begin
                ru_d = x_q; x_d = v_q; steps_d = 8'd0;
            end else begin
                x_d = step_x; steps_d = steps_q + 8'd1;
            end
            S_FIND_V: if (at_root) rv_d = x_q;
                      else begin
                          x_d = step_x; steps_d = steps_q + 8'd1;
                      end
            S_UNION: begin
                if (ru_q != rv_q) begin
                    count_d = count_q + 8'd1;
                    total_d = total_q + {8'h00, w_q};
                end
                k_d = k_q + 8'd1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            n_q <= '0; e_q <= '0; k_q <= '0; i_q <= '0; x_q <= '0; steps_q <= '0;
            u_q <= '0; v_q <= '0; w_q <= '0; ru_q <= '0; rv_q <= '0;
            count_q <= '0; total_q <= '0; rdy_q <= '0; rdata_q <= '0;
        end else begin
            n_q <= n_d; e_q <= e_d; k_q <= k_d; i_q <= i_d; x_q <= x_d; steps_q <= steps_d;
            u_q <= u_d; v_q <= v_d; w_q <= w_d; ru_q <= ru_d; rv_q <= rv_d;
            count_q <= count_d; total_q <= total_d; rdy_q <= rdy_d; rdata_q <= rdata_d;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clock) begin
        for (int p = 0; p < NWP; p++)
            if (wr_en[p]) mem_q[off(wr_addr[p])] <= wr_data[p];
    end

    assign Sout_Rdata_ram     = rdata_q;
    assign Sout_DataRdy       = rdy_q;
    assign Mout_oe_ram        = '0;
    assign Mout_we_ram        = '0;
    assign Mout_addr_ram      = '0;
    assign Mout_Wdata_ram     = '0;
    assign Mout_data_ram_size = '0;
endmodule

// File: tb/tb_kruskal_mst_core.sv
// tb/tb_kruskal_mst_core.sv - randomized bench for kruskal_mst_core against a component-label Kruskal model
module tb_kruskal_mst_core;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_port = 1'b0;
    logic        done_port;
    logic [1:0]  S_oe_ram = '0, S_we_ram = '0;
    logic [21:0] S_addr_ram = '0;
    logic [15:0] S_Wdata_ram = '0;
    logic [7:0]  S_data_ram_size = '0;
    logic [15:0] M_Rdata_ram = '0;
    logic [1:0]  M_DataRdy = '0;
    logic [15:0] Sout_Rdata_ram;
    logic [1:0]  Sout_DataRdy;
    logic [1:0]  Mout_oe_ram, Mout_we_ram;
    logic [21:0] Mout_addr_ram;
    logic [15:0] Mout_Wdata_ram;
    logic [7:0]  Mout_data_ram_size;

    always #5 clock = ~clock;

    kruskal_mst_core dut (
        .clock(clock), .reset(reset), .start_port(start_port), .done_port(done_port),
        .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
        .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
        .M_Rdata_ram(M_Rdata_ram), .M_DataRdy(M_DataRdy),
        .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
        .Mout_oe_ram(Mout_oe_ram), .Mout_we_ram(Mout_we_ram), .Mout_addr_ram(Mout_addr_ram),
        .Mout_Wdata_ram(Mout_Wdata_ram), .Mout_data_ram_size(Mout_data_ram_size)
    );

    int n_vec = 0;
    int n_err = 0;

    int g_n, g_e;
    int g_u [128], g_v [128], g_w [128];
    int exp_cnt, exp_tot;
    int exp_sel [128], exp_mu [128], exp_mv [128], exp_mw [128];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        S_oe_ram = '0; S_we_ram = '0; S_addr_ram = '0; S_Wdata_ram = '0; S_data_ram_size = '0;
    endtask

    task automatic sw(input int ch, input int addr, input int data);
        logic [10:0] a;
        logic [7:0]  d;
        a = addr[10:0];
        d = data[7:0];
        @(posedge clock); #1;
        S_we_ram[ch] = 1'b1;
        S_addr_ram[ch*11 +: 11] = a;
        S_Wdata_ram[ch*8 +: 8] = d;
        S_data_ram_size[ch*4 +: 4] = 4'($urandom_range(0, 15));
        @(posedge clock); #1;
        bus_idle();
    endtask

    task automatic sr(input int ch, input int addr, output logic [7:0] d, output logic r);
        logic [10:0] a;
        a = addr[10:0];
        @(posedge clock); #1;
        S_oe_ram[ch] = 1'b1;
        S_addr_ram[ch*11 +: 11] = a;
        S_data_ram_size[ch*4 +: 4] = 4'($urandom_range(0, 15));
        @(posedge clock); #1;
        bus_idle();
        d = Sout_Rdata_ram[ch*8 +: 8];
        r = Sout_DataRdy[ch];
    endtask

    // Kruskal over connected-component labels; no parent pointers involved.
    task automatic model();
        int nn, ee, cu, cv;
        int comp [28];
        nn = (g_n > 28) ? 28 : g_n;
        ee = (g_e > 128) ? 128 : g_e;
        exp_cnt = 0;
        exp_tot = 0;
        for (int i = 0; i < 28; i++) comp[i] = i;
        for (int k = 0; k < 128; k++) exp_sel[k] = 0;
        for (int k = 0; k < ee; k++) begin
            if (nn <= 1 || exp_cnt == nn - 1) break;
            if (g_u[k] >= nn || g_v[k] >= nn || g_u[k] == g_v[k]) continue;
            cu = comp[g_u[k]];
            cv = comp[g_v[k]];
            if (cu != cv) begin
                for (int i = 0; i < nn; i++) if (comp[i] == cu) comp[i] = cv;
                exp_mu[exp_cnt] = g_u[k];
                exp_mv[exp_cnt] = g_v[k];
                exp_mw[exp_cnt] = g_w[k];
                exp_cnt++;
                exp_tot = (exp_tot + g_w[k]) & 16'hFFFF;
                exp_sel[k] = 1;
            end
        end
    endtask

    task automatic run_graph(input string name, input bit poke);
        int ee, dones;
        bit seen;
        logic [7:0] d;
        logic r;
        ee = (g_e > 128) ? 128 : g_e;
        sw(0, 640, g_n);
        sw(1, 641, g_e);
        for (int k = 0; k < ee; k++) begin
            sw(k & 1, 128 + k, g_u[k]);
            sw((k + 1) & 1, 256 + k, g_v[k]);
            sw(k & 1, 384 + k, g_w[k]);
        end
        model();
        @(posedge clock); #1;
        start_port = 1'b1;
        seen = 0;
        dones = 0;
        for (int c = 0; c < 20000 && !seen; c++) begin
            @(posedge clock); #1;
            start_port = poke && (c == 0);
            if (done_port) seen = 1;
        end
        start_port = 1'b0;
        if (!seen) begin
            check({name, " done_timeout"}, 0, 1);
            return;
        end
        for (int c = 0; c < 8; c++) begin
            @(posedge clock); #1;
            if (done_port) dones++;
        end
        check({name, " extra_done"}, dones, 0);
        sr(0, 1152, d, r);
        check({name, " count"}, d, exp_cnt);
        check({name, " count_rdy"}, r, 1);
        sr(1, 1153, d, r);
        check({name, " tot_lo"}, d, exp_tot & 255);
        sr(0, 1154, d, r);
        check({name, " tot_hi"}, d, exp_tot >> 8);
        for (int k = 0; k < ee; k++) begin
            sr(k & 1, 1280 + k, d, r);
            check($sformatf("%s sel[%0d]", name, k), d, exp_sel[k]);
        end
        for (int i = 0; i < exp_cnt; i++) begin
            sr(0, 768 + i, d, r);
            check($sformatf("%s mst_u[%0d]", name, i), d, exp_mu[i]);
            sr(1, 896 + i, d, r);
            check($sformatf("%s mst_v[%0d]", name, i), d, exp_mv[i]);
            sr(0, 1024 + i, d, r);
            check($sformatf("%s mst_w[%0d]", name, i), d, exp_mw[i]);
        end
    endtask

    task automatic gen_random(input int n, input int e);
        int nn, w;
        nn = (n > 28) ? 28 : n;
        g_n = n;
        g_e = e;
        w = $urandom_range(0, 3);
        for (int k = 0; k < 128; k++) begin
            g_u[k] = $urandom_range(0, nn);
            g_v[k] = $urandom_range(0, nn);
            w = w + $urandom_range(0, 2);
            if (w > 255) w = 255;
            g_w[k] = w;
        end
    endtask

    initial begin
        logic [7:0] d;
        logic r;
        logic any_done, any_rdy, any_m;
        int idx;

        #1;
        check("rst_done", done_port, 0);
        check("rst_rdy", Sout_DataRdy, 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        any_done = 0; any_rdy = 0; any_m = 0;
        for (int c = 0; c < 100; c++) begin
            @(posedge clock); #1;
            any_done |= done_port;
            any_rdy  |= |Sout_DataRdy;
            any_m    |= |{Mout_oe_ram, Mout_we_ram, Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size};
        end
        check("idle_done", any_done, 0);
        check("idle_rdy", any_rdy, 0);
        check("idle_mout", any_m, 0);

        sw(0, 640, 8'h5A);
        check("wr_rdy", Sout_DataRdy, 2'b01);
        sr(1, 640, d, r);
        check("rd_ch1_data", d, 8'h5A);
        check("rd_ch1_rdy", r, 1);

        sr(0, 50, d, r);
        check("miss_data", d, 0);
        check("miss_rdy", r, 0);

        @(posedge clock); #1;
        S_oe_ram = 2'b01; S_we_ram = 2'b01; S_addr_ram = 22'd640; S_Wdata_ram = 16'h0011;
        @(posedge clock); #1;
        bus_idle();
        check("oewe_rdy", Sout_DataRdy, 0);
        sr(0, 640, d, r);
        check("oewe_keep", d, 8'h5A);

        @(posedge clock); #1;
        S_we_ram = 2'b11; S_addr_ram = {11'd700, 11'd700}; S_Wdata_ram = 16'hCC33;
        @(posedge clock); #1;
        bus_idle();
        check("coll_rdy", Sout_DataRdy, 2'b11);
        sr(0, 700, d, r);
        check("coll_ch1_wins", d, 8'hCC);

        g_n = 4; g_e = 4;
        g_u[0] = 0; g_v[0] = 1; g_w[0] = 1;
        g_u[1] = 1; g_v[1] = 2; g_w[1] = 2;
        g_u[2] = 0; g_v[2] = 2; g_w[2] = 3;
        g_u[3] = 2; g_v[3] = 3; g_w[3] = 4;
        run_graph("n4", 0);
        check("n4 model_cnt", exp_cnt, 3);
        check("n4 model_tot", exp_tot, 7);

        g_n = 3; g_e = 1;
        g_u[0] = 0; g_v[0] = 1; g_w[0] = 5;
        run_graph("forest", 0);

        g_n = 1; g_e = 3;
        run_graph("n1", 1);
        g_n = 5; g_e = 0;
        run_graph("e0", 1);

        g_n = 28; g_e = 37; idx = 0;
        for (int k = 0; k < 14; k++) begin g_u[idx] = k; g_v[idx] = k + 1; g_w[idx] = 200; idx++; end
        for (int j = 2; j < 12; j++) begin g_u[idx] = 0; g_v[idx] = j; g_w[idx] = 200; idx++; end
        for (int k = 14; k < 27; k++) begin g_u[idx] = k; g_v[idx] = k + 1; g_w[idx] = 200; idx++; end
        run_graph("chain", 0);
        check("chain model_tot", exp_tot, 5400);

        for (int t = 0; t < 8; t++) begin
            gen_random($urandom_range(2, 28), $urandom_range(1, 60));
            run_graph($sformatf("rnd%0d", t), t[0]);
        end
        gen_random(40, 200);
        run_graph("clamp", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/kruskal_mst_core.md
Name: kruskal_mst_core

Overview:
- Kruskal minimum-spanning-tree engine, 28-node class graphs.
- Host loads a weight-sorted edge list into on-chip byte memories through a two-channel slave RAM port, pulses start_port, then waits for a one-cycle done_port pulse.
- Host then reads the MST edge list and a summary back through the slave port.
- Master RAM port is present for bus compatibility only.

Parameters:
- MEM_var_28867_28882, 128: base of edge_u[0..127].
- MEM_var_28868_28882, 256: base of edge_v[0..127].
- MEM_var_28869_28882, 384: base of edge_w[0..127], unsigned, ascending order required.
- MEM_var_28870_28882, 512: base of parent[0..127], union-find scratch.
- MEM_var_28859_28880, 640: base of config; byte0 = N (nodes), byte1 = E (edges).
- MEM_var_28861_28880, 768: base of mst_u[].
- MEM_var_28862_28880, 896: base of mst_v[].
- MEM_var_28864_28880, 1024: base of mst_w[].
- MEM_var_28865_28880, 1152: base of status; byte0 = MST edge count, byte1/byte2 = total weight low/high.
- MEM_var_28866_28880, 1280: base of sel[0..127]; 1 = input edge taken into the MST.

Ports:
- clock, in, 1: sole clock, rising edge.
- reset, in, 1: asynchronous, active-high.
- start_port, in, 1: start request, sampled when idle.
- done_port, out, 1: one-cycle completion pulse.
- S_oe_ram, in, 2: per-channel slave read enable.
- S_we_ram, in, 2: per-channel slave write enable.
- S_addr_ram, in, 22: ch0 = [10:0], ch1 = [21:11].
- S_Wdata_ram, in, 16: ch0 = [7:0], ch1 = [15:8].
- S_data_ram_size, in, 8: ch0 = [3:0], ch1 = [7:4], access width in bits.
- M_Rdata_ram, in, 16: master read data, unused.
- M_DataRdy, in, 2: master ready, unused.
- Sout_Rdata_ram, out, 16: slave read data, per-channel byte.
- Sout_DataRdy, out, 2: slave access-complete strobe.
- Mout_oe_ram, out, 2: tied 0.
- Mout_we_ram, out, 2: tied 0.
- Mout_addr_ram, out, 22: tied 0.
- Mout_Wdata_ram, out, 16: tied 0.
- Mout_data_ram_size, out, 8: tied 0.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters cleared. Memory contents are not cleared. Reset mid-run aborts with no done_port.
- Memory: ten regions, each 128 bytes, byte-addressed. A channel hits when base <= addr < base+128.
- Slave access, IDLE only:
  - Read: Sout_Rdata byte and Sout_DataRdy bit are valid the cycle after oe.
  - Write: commits at the clock edge; DataRdy pulses the next cycle.
  - Size field other than 8: treated as 8.
  - Miss, or oe and we both set: no action; Rdata 0, DataRdy 0.
  - Both channels to the same byte: ch1 write wins.
  - Sout_Rdata is 0 whenever DataRdy is 0.
  - Accesses while busy are ignored (DataRdy 0).
- FSM states: IDLE -> INIT -> FETCH -> FIND_U -> FIND_V -> UNION -> FETCH ... -> FINISH -> IDLE.
- IDLE: start_port=1 latches N = min(config[0], 28) and E = min(config[1], 128); goes to INIT. start_port outside IDLE is ignored.
- INIT:
  - Writes parent[i]=i for i<N, one per cycle.
  - Clears sel[0..E-1].
  - Clears count and total weight.
- FETCH:
  - Reads edge k (k = 0..E-1) as u, v, w.
  - Skips the edge if u>=N, v>=N or u==v.
- FIND_U / FIND_V: follow parent pointers until parent[x]==x, one read per cycle; the walk is bounded at N steps.
- UNION:
  - Roots differ: parent[root_u]=root_v; append u, v, w at mst[count]; sel[k]=1; count++; total += w (16-bit).
  - Roots equal: edge discarded.
- Termination: after the last edge, or once count == N-1, go to FINISH.
- FINISH: writes status bytes; done_port=1 for exactly one cycle; returns to IDLE.
- N<=1 or E=0: count 0, total 0, done within INIT + FINISH cycles.
- Equal weights: earlier index wins.
- Disconnected graph: result is a spanning forest with count < N-1.

Optional Feature:
- PATH_HALVING_EN defined: during FIND, each step also writes parent[x] = parent[parent[x]]. MST contents are identical; the cycle count is less than or equal to the plain version.
- Undefined: plain find, no parent writes during FIND.

Test Plan:
- Reset with no start -> done_port, Sout_DataRdy and all Mout_* stay 0 for 100 cycles.
- Slave write 0x5A to 640 on ch0, read it back on ch1 -> Sout_Rdata_ram[15:8]=0x5A with Sout_DataRdy[1]=1 one cycle after oe.
- N=4, edges (0,1,1),(1,2,2),(0,2,3),(2,3,4), start -> one done pulse; count=3; total=7; sel = 1,1,0,1; mst_u/v/w match the selected edges in order.
- N=3 with only edge (0,1,5) -> count=1, total=5 (forest).
- N=1 or E=0 -> done pulse, count=0, total=0; start pulsed while busy is ignored (single done).
- N=28 chain of 27 edges of weight 200 plus 10 redundant edges -> count=27, total=5400 (0x1518), redundant sel=0; same results with and without PATH_HALVING_EN.
